// File: rtl/vga_key_pkg.sv
// Shared types and clock-derived defaults for the push-button conditioning path
// feeding the VGA display stage.
package vga_key_pkg;

    localparam int unsigned PIX_CLK_HZ  = 83_580_000;
    localparam int unsigned DEBOUNCE_MS = 20;

    localparam int unsigned DEF_DEBOUNCE_CYCLES = (PIX_CLK_HZ / 1000) * DEBOUNCE_MS;
    localparam int unsigned DEF_HOLD_CYCLES     = PIX_CLK_HZ;
    localparam int unsigned DEF_CNT_W           = 27;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_FILT   = 2'd1,
        DOWN         = 2'd2,
        RELEASE_FILT = 2'd3
    } kd_state_e;

endpackage

// File: rtl/key_debounce_if.sv
// Button-side bundle: raw active-low key in, debounced events and level out.
interface key_debounce_if;

    logic key_n;
    logic flag;
    logic release_flag;
    logic long_flag;
    logic key_state;

    modport master (
        output key_n,
        input  flag,
        input  release_flag,
        input  long_flag,
        input  key_state
    );

    modport slave (
        input  key_n,
        output flag,
        output release_flag,
        output long_flag,
        output key_state
    );

endinterface

// File: rtl/key_debounce_sync_edge.sv
// Two-flop synchronizer plus a delay flop for single-cycle fall/rise detection;
// reusable for any asynchronous button input.
module sync_edge #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic async_i,
    output logic sync_o,
    output logic fall_o,
    output logic rise_o
);

    logic meta_q;
    logic key_s_q;
    logic key_d_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q  <= RST_VAL;
            key_s_q <= RST_VAL;
            key_d_q <= RST_VAL;
        end else begin
            meta_q  <= async_i;
            key_s_q <= meta_q;
            key_d_q <= key_s_q;
        end
    end

    assign sync_o = key_s_q;
    assign fall_o = key_d_q & ~key_s_q;
    assign rise_o = ~key_d_q & key_s_q;

endmodule

// File: rtl/key_debounce.sv
// Debounces an active-low push-button into press/release/long-press pulses and
// a clean pressed level, using one shared down-timer for all qualification.
module key_debounce
    import vga_key_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned HOLD_CYCLES     = DEF_HOLD_CYCLES,
    parameter int unsigned CNT_W           = DEF_CNT_W
) (
    input  logic           clk,
    input  logic           rst,
    key_debounce_if.slave  kif
);

    localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_MAX  = CNT_W'(HOLD_CYCLES);

    logic key_s;
    logic fall;
    logic rise;

    sync_edge #(
        .RST_VAL (1'b1)
    ) u_sync_edge (
        .clk     (clk),
        .rst     (rst),
        .async_i (kif.key_n),
        .sync_o  (key_s),
        .fall_o  (fall),
        .rise_o  (rise)
    );

    kd_state_e        state_q;
    logic [CNT_W-1:0] timer_q;
    logic [CNT_W-1:0] timer_inc_d;
    logic [CNT_W-1:0] timer_sat_d;
    logic             long_done_q;
    logic             flag_q;
    logic             release_flag_q;
    logic             long_flag_q;
    logic             key_state_q;

    always_comb begin
        timer_inc_d = timer_q + CNT_W'(1);
        timer_sat_d = (timer_q == HOLD_MAX) ? timer_q : timer_inc_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            timer_q        <= '0;
            long_done_q    <= 1'b0;
            flag_q         <= 1'b0;
            release_flag_q <= 1'b0;
            long_flag_q    <= 1'b0;
            key_state_q    <= 1'b0;
        end else begin
            flag_q         <= 1'b0;
            release_flag_q <= 1'b0;
            long_flag_q    <= 1'b0;

            case (state_q)
                IDLE: begin
                    if (fall) begin
                        state_q <= PRESS_FILT;
                        timer_q <= '0;
                    end
                end

                // An edge on the terminal cycle wins over qualification.
                PRESS_FILT: begin
                    if (rise) begin
                        state_q     <= IDLE;
                        timer_q     <= '0;
                        long_done_q <= 1'b0;
                    end else if (timer_q == DEB_LAST) begin
                        timer_q <= '0;
                        if (!key_s) begin
                            state_q     <= DOWN;
                            flag_q      <= 1'b1;
                            key_state_q <= 1'b1;
                        end else begin
                            state_q     <= IDLE;
                            long_done_q <= 1'b0;
                        end
                    end else begin
                        timer_q <= timer_inc_d;
                    end
                end

                DOWN: begin
                    if (rise) begin
                        state_q <= RELEASE_FILT;
                        timer_q <= '0;
                    end else begin
                        timer_q <= timer_sat_d;
                        if (timer_q == HOLD_LAST && !long_done_q) begin
                            long_flag_q <= 1'b1;
                            long_done_q <= 1'b1;
                        end
                    end
                end

                // A bounce back to DOWN keeps counting from the release-filter
                // value rather than restoring the hold time.
                RELEASE_FILT: begin
                    if (fall) begin
                        state_q <= DOWN;
                        timer_q <= timer_inc_d;
                    end else if (timer_q == DEB_LAST) begin
                        timer_q <= '0;
                        if (key_s) begin
                            state_q        <= IDLE;
                            release_flag_q <= 1'b1;
                            key_state_q    <= 1'b0;
                            long_done_q    <= 1'b0;
                        end else begin
                            state_q <= DOWN;
                        end
                    end else begin
                        timer_q <= timer_inc_d;
                    end
                end

                default: begin
                    state_q     <= IDLE;
                    timer_q     <= '0;
                    long_done_q <= 1'b0;
                    key_state_q <= 1'b0;
                end
            endcase
        end
    end

    assign kif.flag         = flag_q;
    assign kif.release_flag = release_flag_q;
    assign kif.long_flag    = long_flag_q;
    assign kif.key_state    = key_state_q;

endmodule

// File: tb/tb_key_debounce.sv
// Randomized and directed bench for key_debounce: a run-length reference model
// schedules expected pulses into a queue that a negedge monitor consumes.
module tb_key_debounce;

    localparam int unsigned D = 16;
    localparam int unsigned H = 64;
    localparam int unsigned W = 8;
    localparam int          RUN_CAP = 1000;

    localparam int K_FLAG = 0;
    localparam int K_REL  = 1;
    localparam int K_LONG = 2;

    typedef struct {
        int cyc;
        int kind;
    } ev_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic key_n = 1'b1;

    key_debounce_if kif();
    assign kif.key_n = key_n;

    key_debounce #(
        .DEBOUNCE_CYCLES (D),
        .HOLD_CYCLES     (H),
        .CNT_W           (W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .kif (kif)
    );

    always #5 clk = ~clk;

    ev_t exp_q[$];
    int  n_cmp = 0;
    int  n_bad = 0;
    int  cyc = 0;

    // Reference model state: synchronized level history as run lengths.
    logic m_s1 = 1'b1;
    logic m_ks = 1'b1;
    int   m_run = RUN_CAP;
    logic m_pressed = 1'b0;
    logic m_done = 1'b0;
    int   m_ref = 0;

    int flag_cnt = 0, rel_cnt = 0, long_cnt = 0;
    int last_flag = -1, last_rel = -1, last_long = -1;
    int disp_cnt = 0;

    task automatic push_ev(input int kind);
        ev_t e;
        e.cyc  = cyc;
        e.kind = kind;
        exp_q.push_back(e);
    endtask

    // A press qualifies once the synchronized key has read low for D+1 samples
    // since its fall; release likewise for high. Long press fires H cycles after
    // qualification or after the latest rise seen while pressed.
    task automatic model_step();
        cyc = cyc + 1;
        if (rst) begin
            m_s1 = 1'b1; m_ks = 1'b1; m_run = RUN_CAP;
            m_pressed = 1'b0; m_done = 1'b0;
        end else begin
            if (!m_pressed && !m_ks && m_run == int'(D) + 1) begin
                push_ev(K_FLAG); m_pressed = 1'b1; m_ref = cyc; m_done = 1'b0;
            end else if (m_pressed && m_ks && m_run == int'(D) + 1) begin
                push_ev(K_REL); m_pressed = 1'b0;
            end else if (m_pressed && m_ks && m_run == 1) begin
                m_ref = cyc;
            end else if (m_pressed && !m_done && cyc - m_ref == int'(H)) begin
                push_ev(K_LONG); m_done = 1'b1;
            end
            if (m_s1 == m_ks) m_run = (m_run < RUN_CAP) ? m_run + 1 : m_run;
            else              m_run = 1;
            m_ks = m_s1;
            m_s1 = key_n;
        end
    endtask

    task automatic monitor_step();
        ev_t e;
        int  np;
        int  kind;
        if (rst) begin
            n_cmp++;
            if ({kif.flag, kif.release_flag, kif.long_flag, kif.key_state} != 4'b0000) begin
                n_bad++;
                $display("FAIL rst_outputs: cycle %0d got %b expected 0000", cyc,
                         {kif.flag, kif.release_flag, kif.long_flag, kif.key_state});
            end
            exp_q.delete();
            disp_cnt = 0;
        end else begin
            while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                e = exp_q.pop_front();
                n_cmp++; n_bad++;
                $display("FAIL missed_pulse: kind %0d due cycle %0d not seen by cycle %0d",
                         e.kind, e.cyc, cyc);
            end
            np = int'(kif.flag) + int'(kif.release_flag) + int'(kif.long_flag);
            if (np > 1) begin
                n_cmp++; n_bad++;
                $display("FAIL pulse_excl: cycle %0d got %0d pulses expected at most 1", cyc, np);
            end else if (np == 1) begin
                kind = kif.flag ? K_FLAG : (kif.release_flag ? K_REL : K_LONG);
                if (kind == K_FLAG) begin flag_cnt++; last_flag = cyc; disp_cnt++; end
                if (kind == K_REL)  begin rel_cnt++;  last_rel  = cyc; end
                if (kind == K_LONG) begin long_cnt++; last_long = cyc; end
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL unexpected_pulse: kind %0d at cycle %0d, none expected", kind, cyc);
                end else begin
                    e = exp_q.pop_front();
                    if (e.kind != kind || e.cyc != cyc) begin
                        n_bad++;
                        $display("FAIL pulse: got kind %0d at cycle %0d expected kind %0d at cycle %0d",
                                 kind, cyc, e.kind, e.cyc);
                    end
                end
            end
            n_cmp++;
            if (kif.key_state !== m_pressed) begin
                n_bad++;
                $display("FAIL key_state: cycle %0d got %b expected %b", cyc, kif.key_state, m_pressed);
            end
        end
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin : main
        int t0, t1, tr, f0, r0, l0;
        fork
            forever begin @(posedge clk); model_step();   end
            forever begin @(negedge clk); monitor_step(); end
        join_none

        tick(3);
        rst = 1'b0;
        tick(10);

        // Clean press
        f0 = flag_cnt; r0 = rel_cnt;
        key_n = 1'b0; t0 = cyc;
        tick(100);
        key_n = 1'b1; t1 = cyc;
        tick(40);
        check("clean_flag_cycle", last_flag, t0 + int'(D) + 3);
        check("clean_rel_cycle",  last_rel,  t1 + int'(D) + 3);
        check("clean_flag_count", flag_cnt - f0, 1);
        check("clean_rel_count",  rel_cnt - r0, 1);

        // Bounce: toggle every 5 cycles, then settle low
        f0 = flag_cnt;
        for (int i = 0; i < 8; i++) begin
            key_n = ~key_n;
            tick(5);
        end
        check("bounce_no_flag", flag_cnt - f0, 0);
        key_n = 1'b0; t0 = cyc;
        tick(60);
        key_n = 1'b1;
        tick(40);
        check("bounce_flag_cycle", last_flag, t0 + int'(D) + 3);
        check("bounce_flag_count", flag_cnt - f0, 1);

        // Glitch shorter than qualification
        f0 = flag_cnt; r0 = rel_cnt;
        key_n = 1'b0;
        tick(10);
        key_n = 1'b1;
        tick(40);
        check("glitch_flag_count", flag_cnt - f0, 0);
        check("glitch_rel_count",  rel_cnt - r0, 0);

        // Long press with a short release bounce mid-hold
        f0 = flag_cnt; r0 = rel_cnt; l0 = long_cnt;
        key_n = 1'b0; t0 = cyc;
        tick(120);
        key_n = 1'b1;
        tick(8);
        key_n = 1'b0;
        tick(72);
        key_n = 1'b1;
        tick(40);
        check("long_cycle",      last_long, t0 + int'(D) + 3 + int'(H));
        check("long_count",      long_cnt - l0, 1);
        check("long_flag_count", flag_cnt - f0, 1);
        check("long_rel_count",  rel_cnt - r0, 1);

        // Reset while pressed and held
        key_n = 1'b0;
        tick(40);
        rst = 1'b1;
        tick(3);
        rst = 1'b0; tr = cyc; f0 = flag_cnt;
        tick(40);
        check("rst_flag_cycle", last_flag, tr + int'(D) + 3);
        check("rst_flag_count", flag_cnt - f0, 1);
        key_n = 1'b1;
        tick(40);

        // Integration: three presses into the display counter
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(5);
        for (int i = 0; i < 3; i++) begin
            key_n = 1'b0; tick(40);
            key_n = 1'b1; tick(40);
        end
        check("disp_count",   disp_cnt, 3);
        check("disp_image_b", disp_cnt % 2, 1);

        // Randomized level segments with occasional resets
        for (int i = 0; i < 150; i++) begin
            if ($urandom_range(0, 39) == 0) begin
                rst = 1'b1;
                tick(int'($urandom_range(1, 3)));
                rst = 1'b0;
            end
            key_n = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) tick(int'($urandom_range(20, 120)));
            else                           tick(int'($urandom_range(1, 20)));
        end
        key_n = 1'b1;
        tick(60);
        check("queue_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
